// File: rtl/mem_read_checker.sv
// mem_read_checker: sweeps every RAM address once, aligns read data with its address
// and checks it against the address+OFFSET pattern, reporting error count and first failure.
module mem_read_checker #(
   parameter int          ADDR_W = 10,
   parameter int          DATA_W = 32,
   parameter int          RD_LAT = 2,
   parameter int unsigned OFFSET = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd_en,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_q,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [15:0]       err_count,
   output logic [ADDR_W-1:0] first_err_addr,
   output logic [DATA_W-1:0] first_err_data,
   output logic [DATA_W-1:0] last_data
);
   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
   localparam logic [1:0] DR_LAST = 2'(RD_LAT - 1);
   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [1:0]          dcnt_q, dcnt_d;
   logic [15:0]         err_q, err_d;
   logic [ADDR_W-1:0]   fa_q, fa_d;
   logic [DATA_W-1:0]   fd_q, fd_d;
   logic [DATA_W-1:0]   last_q, last_d;
   logic [RD_LAT-1:0]   vld_q;
   logic [ADDR_W-1:0]   pa_q [RD_LAT];
   logic                flush, hit, miss;
   logic [DATA_W-1:0]   exp_w;
   assign mem_addr       = addr_q;
   assign mem_rd_en      = state_q == READ;
   assign mem_we         = 1'b0;
   assign busy           = state_q == READ || state_q == DRAIN;
   assign done           = state_q == DONE;
   assign pass           = done && err_q == 16'd0;
   assign err_count      = err_q;
   assign first_err_addr = fa_q;
   assign first_err_data = fd_q;
   assign last_data      = last_q;
   assign flush          = start && (state_q == IDLE || state_q == DONE);
   assign hit            = vld_q[RD_LAT-1];
   assign exp_w          = DATA_W'(pa_q[RD_LAT-1]) + DATA_W'(OFFSET);
   assign miss           = hit && mem_q != exp_w;
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      dcnt_d  = dcnt_q;
      err_d   = err_q;
      fa_d    = fa_q;
      fd_d    = fd_q;
      last_d  = hit ? mem_q : last_q;
      if (miss) begin
         fa_d  = err_q == 16'd0 ? pa_q[RD_LAT-1] : fa_q;
         fd_d  = err_q == 16'd0 ? mem_q : fd_q;
         err_d = err_q == 16'hFFFF ? err_q : err_q + 16'd1;
      end
      case (state_q)
         READ: begin
            state_d = addr_q == '1 ? DRAIN : READ;
            addr_d  = addr_q == '1 ? addr_q : addr_q + 1'b1;
            dcnt_d  = 2'd0;
         end
         DRAIN: begin
            state_d = dcnt_q == DR_LAST ? DONE : DRAIN;
            dcnt_d  = dcnt_q + 2'd1;
         end
         default: ;
      endcase
      // a new sweep starts from clean results regardless of any in-flight compare
      if (flush) begin
         state_d = READ;
         addr_d  = '0;
         err_d   = '0;
         fa_d    = '0;
         fd_d    = '0;
         last_d  = '0;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         dcnt_q  <= '0;
         err_q   <= '0;
         fa_q    <= '0;
         fd_q    <= '0;
         last_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         dcnt_q  <= dcnt_d;
         err_q   <= err_d;
         fa_q    <= fa_d;
         fd_q    <= fd_d;
         last_q  <= last_d;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q <= '0;
         for (int i = 0; i < RD_LAT; i++) pa_q[i] <= '0;
      end else begin
         vld_q[0] <= mem_rd_en && !flush;
         pa_q[0]  <= mem_addr;
         for (int i = 1; i < RD_LAT; i++) begin
            vld_q[i] <= vld_q[i-1] && !flush;
            pa_q[i]  <= pa_q[i-1];
         end
      end
   end
endmodule

// File: tb/tb_mem_read_checker.sv
// tb_mem_read_checker: random and directed sweeps of two checker instances
// (default latency, and RD_LAT=1 with OFFSET=0x100) against a behavioural RAM scan model.
module tb_mem_read_checker;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start0 = 1'b0, start1 = 1'b0;
   logic [9:0]  addr0, addr1, fa0, fa1;
   logic        rd0, rd1, we0, we1, busy0, busy1, done0, done1, pass0, pass1;
   logic [31:0] q0, q1, fd0, fd1, ld0, ld1, r0a;
   logic [15:0] ec0, ec1;
   logic [31:0] mem0 [1024];
   logic [31:0] mem1 [1024];
   int vectors = 0, miscompares = 0;
   int cyc;

   always #5 clk = ~clk;

   mem_read_checker dut0 (
      .clk(clk), .rst(rst), .start(start0), .mem_addr(addr0), .mem_rd_en(rd0), .mem_we(we0),
      .mem_q(q0), .busy(busy0), .done(done0), .pass(pass0), .err_count(ec0),
      .first_err_addr(fa0), .first_err_data(fd0), .last_data(ld0));

   mem_read_checker #(.RD_LAT(1), .OFFSET(32'h100)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .mem_addr(addr1), .mem_rd_en(rd1), .mem_we(we1),
      .mem_q(q1), .busy(busy1), .done(done1), .pass(pass1), .err_count(ec1),
      .first_err_addr(fa1), .first_err_data(fd1), .last_data(ld1));

   always @(posedge clk) begin
      r0a <= mem0[addr0];
      q0  <= r0a;
      q1  <= mem1[addr1];
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic void model(input bit s, output logic [15:0] ec, output logic [9:0] fa,
                                 output logic [31:0] fd, output logic [31:0] ld);
      logic [31:0] w;
      ec = 0; fa = 0; fd = 0;
      for (int i = 0; i < 1024; i++) begin
         w = s ? mem1[i] : mem0[i];
         if (w != 32'(i) + (s ? 32'h100 : 32'h0)) begin
            if (ec == 0) begin fa = 10'(i); fd = w; end
            ec++;
         end
      end
      ld = s ? mem1[1023] : mem0[1023];
   endfunction

   task automatic fill_clean();
      for (int i = 0; i < 1024; i++) begin
         mem0[i] = 32'(i);
         mem1[i] = 32'(i) + 32'h100;
      end
   endtask

   task automatic do_start(input bit s);
      @(posedge clk); #1;
      if (s) start1 = 1'b1; else start0 = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0; start1 = 1'b0;
   endtask

   task automatic wait_done(input bit s, input int c0, output int c);
      c = c0;
      while (!(s ? done1 : done0) && c < 3000) begin
         @(posedge clk); #1;
         c++;
      end
   endtask

   task automatic check_result(input bit s, input string tag, input int c);
      logic [15:0] ec; logic [9:0] fa; logic [31:0] fd, ld;
      model(s, ec, fa, fd, ld);
      check({tag, "_done_cycle"}, c, s ? 1026 : 1027);
      check({tag, "_done"}, s ? done1 : done0, 1);
      check({tag, "_busy"}, s ? busy1 : busy0, 0);
      check({tag, "_pass"}, s ? pass1 : pass0, ec == 0);
      check({tag, "_err_count"}, s ? ec1 : ec0, ec);
      check({tag, "_first_addr"}, s ? fa1 : fa0, fa);
      check({tag, "_first_data"}, s ? fd1 : fd0, fd);
      check({tag, "_last_data"}, s ? ld1 : ld0, ld);
      repeat (3) @(posedge clk);
      #1;
      check({tag, "_stable_err"}, s ? ec1 : ec0, ec);
      check({tag, "_stable_done"}, s ? done1 : done0, 1);
   endtask

   task automatic sweep(input bit s, input string tag);
      do_start(s);
      check({tag, "_busy_c1"}, s ? busy1 : busy0, 1);
      check({tag, "_addr_c1"}, s ? addr1 : addr0, 0);
      wait_done(s, 1, cyc);
      check_result(s, tag, cyc);
   endtask

   initial begin
      fill_clean();
      #12;
      check("rst_busy", busy0, 0);
      check("rst_done", done0, 0);
      check("rst_pass", pass0, 0);
      check("rst_we", we0, 0);
      check("rst_rd_en", rd0, 0);
      check("rst_err", ec0, 0);
      check("rst_addr", addr0, 0);
      check("rst_last", ld0, 0);
      @(posedge clk); #1 rst = 1'b0;

      sweep(0, "clean");
      check("clean_last_3ff", ld0, 32'h3FF);

      mem0[10'h155] = 32'hDEADBEEF;
      sweep(0, "single");
      check("single_count", ec0, 1);
      check("single_addr", fa0, 10'h155);

      fill_clean();
      mem0[3] = 32'h1234_5678;
      mem0[1023] = 32'h0;
      sweep(0, "two");
      check("two_count", ec0, 2);

      for (int t = 0; t < 4; t++) begin
         fill_clean();
         for (int j = $urandom_range(0, 6); j > 0; j--)
            mem0[$urandom_range(0, 1023)] = $urandom;
         if (t[0]) mem0[1023] = $urandom;
         sweep(0, $sformatf("rand%0d", t));
      end

      fill_clean();
      mem0[7] = 32'hFFFF_FFFF;
      do_start(0);
      repeat (399) @(posedge clk);
      #1 start0 = 1'b1;
      @(posedge clk); #1 start0 = 1'b0;
      wait_done(0, 401, cyc);
      check_result(0, "ignored", cyc);
      fill_clean();
      sweep(0, "rerun");

      for (int i = 0; i < 1024; i += 5) mem0[i] = ~32'(i);
      do_start(0);
      repeat (499) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("mid_rst_busy", busy0, 0);
      check("mid_rst_rd_en", rd0, 0);
      check("mid_rst_addr", addr0, 0);
      check("mid_rst_err", ec0, 0);
      check("mid_rst_fa", fa0, 0);
      check("mid_rst_fd", fd0, 0);
      check("mid_rst_last", ld0, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      check("post_rst_last", ld0, 0);
      check("post_rst_err", ec0, 0);
      check("post_rst_done", done0, 0);
      sweep(0, "after_rst");
      fill_clean();
      sweep(0, "after_rst_clean");

      sweep(1, "lat1_clean");
      check("lat1_last", ld1, 32'h4FF);
      mem1[$urandom_range(0, 1023)] = 32'hCAFE_0000 | 32'($urandom_range(0, 255));
      sweep(1, "lat1_fault");
      check("lat1_fault_count", ec1, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/mem_read_checker.md
# mem_read_checker

Read-back and verification engine for the 1024-word on-chip RAM that `memory_block` fills with the address pattern. On a start pulse it sweeps every RAM address once, aligns returned data with the issued address through a latency-matched pipeline, and compares each word against the expected pattern. It reports an error count, the first failing address and data, and a pass/done status for the top level and the board LEDs.

## Interface

Parameters
- `ADDR_W`, 10: RAM address width; DEPTH = 2**ADDR_W.
- `DATA_W`, 32: RAM data width.
- `RD_LAT`, 2: RAM read latency in cycles, from address to `mem_q`. Legal values are 1..3.
- `OFFSET`, 0: expected word = zero-extended address + OFFSET, modulo 2**DATA_W.

Ports
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: single-cycle request; accepted only in IDLE or DONE.
- `mem_addr` out ADDR_W: RAM read address.
- `mem_rd_en` out 1: high in every cycle that issues a read.
- `mem_we` out 1: tied to 0; this block never writes.
- `mem_q` in DATA_W: RAM read data, valid RD_LAT cycles after its address.
- `busy` out 1: high in READ and DRAIN.
- `done` out 1: high in DONE.
- `pass` out 1: `done` and `err_count` == 0.
- `err_count` out 16: number of mismatches; saturates at 0xFFFF.
- `first_err_addr` out ADDR_W: address of the first mismatch.
- `first_err_data` out DATA_W: data read at the first mismatch.
- `last_data` out DATA_W: the most recently compared word.

## Operation

The state machine has four states:
- **IDLE**: the reset state. `start` moves it to READ.
- **READ**: lasts DEPTH cycles. Each cycle drives `mem_rd_en`=1 and `mem_addr`=a, where a counts 0..DEPTH-1. After the cycle with a = DEPTH-1 the machine moves to DRAIN.
- **DRAIN**: lasts RD_LAT cycles. `mem_rd_en`=0 and `mem_addr` holds DEPTH-1. It then moves to DONE.
- **DONE**: held until `start` is seen, then moves to READ. There is no automatic restart.

`start` is ignored in READ and DRAIN.

Align pipeline:
- A shift register of depth RD_LAT carries {valid, addr} alongside each read, where valid = `mem_rd_en`.
- When the tap at the end of the pipeline is valid, the block compares `mem_q` with the pipelined addr + OFFSET.
- Every compare updates `last_data` to `mem_q`.

On a mismatch:
- If `err_count` == 0, `first_err_addr` and `first_err_data` are captured.
- `err_count` increments, holding at 0xFFFF once it gets there.

Start from IDLE or DONE:
- In the same edge that enters READ, `err_count`, `first_err_addr`, `first_err_data` and `last_data` clear to 0, and the address counter clears to 0.
- The align pipeline is flushed.

Results stay stable in DONE until the next start.

Width rules:
- The address counter is ADDR_W bits.
- The expected value is computed at DATA_W bits and wraps.

Reset, at any time including mid-READ or mid-DRAIN:
- State returns to IDLE and the pipeline valid bits clear.
- All outputs go to 0: `mem_addr`, `mem_rd_en`, `busy`, `done`, `pass`, `err_count`, `first_err_addr`, `first_err_data` and `last_data`.
- After reset deasserts, no compare may fire from stale pipeline contents.

## Timing

Cycle numbering: cycle 0 is the cycle in which `start` is high and sampled.
- **Cycles 1..DEPTH:** READ. `busy`=1, `mem_addr` = cycle-1.
- **Compares:** the read issued in cycle n is compared at the edge ending cycle n+RD_LAT. Its results are visible from cycle n+RD_LAT+1.
- **Cycles DEPTH+1..DEPTH+RD_LAT:** DRAIN. `busy`=1.
- **Cycle DEPTH+RD_LAT+1:** `done`=1, `busy`=0, and the final compare result is already reflected.

Latency from start to done is DEPTH+RD_LAT+1 cycles: 1027 at the defaults, 1026 for RD_LAT=1.

`pass` and `done` rise in the same cycle.

`start` arriving in the same cycle that DRAIN exits is ignored. `start` in the first DONE cycle is accepted.

## Test plan

- **Clean sweep.** RAM model holds the address pattern, RD_LAT=2, `start` pulse at cycle 0 → `done`=1 and `pass`=1 at cycle 1027, `err_count`=0, `last_data`=0x000003FF.
- **Single fault.** Word 0x155 corrupted to 0xDEADBEEF → `err_count`=1, `first_err_addr`=0x155, `first_err_data`=0xDEADBEEF, `pass`=0.
- **Two faults.** Words 3 and 1023 corrupted → `err_count`=2, `first_err_addr`=3. The last-word error is counted before `done` rises.
- **Ignored start, then rerun.** Extra `start` pulse at cycle 400 → no effect; `done` still at cycle 1027. A rerun from DONE with a clean RAM clears the error fields and ends with `pass`=1.
- **Reset mid-READ.** `rst` pulsed in cycle 500 → all outputs 0 immediately. No compare fires afterwards. A new `start` completes a full 1027-cycle sweep.
- **RD_LAT=1, OFFSET=0x100.** RAM holds addr+0x100 → `done` at cycle 1026, `pass`=1.
